pkt_tx: RTL and testbench

PKT_TX -- requirements
Module: pkt_tx

---
 rtl/pkt_tx_pkg.sv | 29 ++
 rtl/pkt_tx_crc32.sv | 37 +++
 rtl/pkt_tx.sv | 135 +++++++++++++
 tb/tb_pkt_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_tx_pkg.sv
// Shared types and constants for the pkt_tx line transmitter.
// The state enum always lists CRC; it is only reachable when PKT_TX_CRC_EN is defined.
package pkt_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    CRC,
    IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_tx_crc32.sv
// Byte-wide reflected CRC-32 accumulator with synchronous clear and enable.
// Holds the raw (non-inverted) remainder; the caller applies CRC32_XOROUT.
module pkt_tx_crc32
  import pkt_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // LSB-first shift: fold the byte into the low bits, then eight division steps
  always_comb begin
    crc_d = crc_q ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      crc_d = crc_d[0] ? ((crc_d >> 1) ^ POLY_REFL) : (crc_d >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      crc_q <= CRC32_INIT;
    end else if (en) begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/pkt_tx.sv
// Framing transmitter: preamble, SFD, streamed payload, optional CRC-32, inter-frame gap.
// Define PKT_TX_CRC_EN to append the 4-byte FCS after the payload.
module pkt_tx
  import pkt_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       busy,
  output logic       tx_underflow
);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [7:0] txd_next;
  logic       tx_en_next;
  logic       underflow_next;
  logic       xfer;

  assign s_ready = (state == SFD) || (state == DATA);
  assign xfer    = s_valid && s_ready;
  assign busy    = (state != IDLE);

`ifdef PKT_TX_CRC_EN
  logic [31:0] crc_raw;
  logic [31:0] crc_out;

  pkt_tx_crc32 u_crc32 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .en    (xfer),
    .data  (s_data),
    .crc   (crc_raw)
  );

  assign crc_out = crc_raw ^ CRC32_XOROUT;
  localparam state_t AFTER_LAST = CRC;
`else
  localparam state_t AFTER_LAST = IFG;
`endif

  // Output registers are loaded with the byte for the cycle after the edge, so the
  // first IFG (or CRC) cycle still shows the final byte of the previous phase.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    txd_next       = 8'h00;
    tx_en_next     = 1'b0;
    underflow_next = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          state_next = PREAMBLE;
          cnt_next   = 8'd0;
          txd_next   = PREAMBLE_BYTE;
          tx_en_next = 1'b1;
        end
      end
      PREAMBLE: begin
        tx_en_next = 1'b1;
        if (cnt == 8'(PREAMBLE_LEN - 1)) begin
          state_next = SFD;
          cnt_next   = 8'd0;
          txd_next   = SFD_BYTE;
        end else begin
          cnt_next = cnt + 8'd1;
          txd_next = PREAMBLE_BYTE;
        end
      end
      SFD, DATA: begin
        cnt_next = 8'd0;
        if (xfer) begin
          txd_next   = s_data;
          tx_en_next = 1'b1;
          state_next = s_last ? AFTER_LAST : DATA;
        end else begin
          state_next     = IFG;
          underflow_next = 1'b1;
        end
      end
`ifdef PKT_TX_CRC_EN
      CRC: begin
        tx_en_next = 1'b1;
        txd_next   = crc_out[{cnt[1:0], 3'b000} +: 8];
        if (cnt == 8'd3) begin
          state_next = IFG;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
`endif
      IFG: begin
        if (cnt == 8'(IFG_LEN - 1)) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      txd          <= 8'h00;
      tx_en        <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      txd          <= txd_next;
      tx_en        <= tx_en_next;
      tx_underflow <= underflow_next;
    end
  end

endmodule

// File: tb/tb_pkt_tx.sv
// Self-checking bench for pkt_tx: a streaming source feeds frames, a frame-level
// scoreboard predicts line bytes, gaps, ready cycles and abort pulses.
module tb_pkt_tx;

  localparam int PRE = 7;
  localparam int IFG = 12;
`ifdef PKT_TX_CRC_EN
  localparam int CRC_TAIL = 4;
`else
  localparam int CRC_TAIL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] txd;
  logic       tx_en;
  logic       busy;
  logic       tx_underflow;

  pkt_tx #(.PREAMBLE_LEN(PRE), .IFG_LEN(IFG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .txd          (txd),
    .tx_en        (tx_en),
    .busy         (busy),
    .tx_underflow (tx_underflow)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [7:0] src_q[$];
  int  src_len = 0, src_supply = 0, src_idx = 0, idle_left = 0;
  bit  src_active = 0, abort_sent = 0, xfer_pending = 0;

  logic [7:0] exp_bytes[$];
  int  exp_flen[$], exp_abort[$], exp_gap[$], exp_ready[$];
  bit  in_run = 0, have_prev = 0, prev_aborted = 0;
  int  run_len = 0, ready_in_run = 0, zero_run = 0;
  int  idle_txd_viol = 0, ready_viol = 0, uf_cnt = 0, abort_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] crcModel(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h000000, src_q[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic driveInputs();
    if (src_active && src_idx == src_len) src_active = 0;
    if (src_active && abort_sent) src_active = 0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
    if (src_active) begin
      if (idle_left > 0) begin
        idle_left--;
      end else if (src_idx < src_supply) begin
        s_valid = 1'b1;
        s_data  = src_q[src_idx];
        s_last  = (src_idx == src_len - 1);
      end else begin
        abort_sent = 1;
      end
    end
    xfer_pending = s_valid && s_ready;
  endtask

  // Segments the line into tx_en runs and checks each against the expected frame.
  task automatic monitor();
    if (tx_en === 1'b1) begin
      if (!in_run) begin
        in_run = 1;
        run_len = 0;
        ready_in_run = 0;
        if (exp_gap.size() == 0) checkOutput("unexpected_frame", 32'(tx_en), 32'd0);
        else if (exp_gap[0] >= 0) checkOutput("ifg_gap", zero_run, exp_gap[0]);
      end
      run_len++;
      if (s_ready === 1'b1) ready_in_run++;
      if (exp_bytes.size() == 0) checkOutput("extra_byte", 32'(tx_en), 32'd0);
      else checkOutput("txd", 32'(txd), 32'(exp_bytes.pop_front()));
      zero_run = 0;
    end else begin
      if (in_run) begin
        in_run = 0;
        if (exp_flen.size() > 0) begin
          checkOutput("frame_len", run_len, exp_flen.pop_front());
          checkOutput("underflow_pulse", 32'(tx_underflow), exp_abort.pop_front());
          checkOutput("ready_cycles", ready_in_run, exp_ready.pop_front());
          void'(exp_gap.pop_front());
        end
        zero_run = 0;
      end
      zero_run++;
      if (txd !== 8'h00) idle_txd_viol++;
      if (s_ready !== 1'b0) ready_viol++;
    end
    if (tx_underflow === 1'b1) uf_cnt++;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (xfer_pending) src_idx++;
    monitor();
    driveInputs();
  endtask

  // Queues one frame on the source as soon as the previous one is finished with.
  task automatic applyStimulus(input int len, input int supply, input int pre_idle, input bit digits);
    int budget;
    bit aborted;
    logic [31:0] fcs;
    budget = 0;
    while (src_active && budget < 1000) begin
      stepCycle();
      budget++;
    end
    if (src_active) begin
      checkOutput("source_timeout", 32'(src_active), 32'd0);
      src_active = 0;
    end
    src_q.delete();
    for (int i = 0; i < len; i++) begin
      src_q.push_back(digits ? 8'(8'h31 + i) : 8'($urandom_range(0, 255)));
    end
    aborted = (supply < len);
    for (int i = 0; i < PRE; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    for (int i = 0; i < supply; i++) exp_bytes.push_back(src_q[i]);
    fcs = crcModel(len);
    if (!aborted) begin
      for (int i = 0; i < CRC_TAIL; i++) exp_bytes.push_back(fcs[8*i +: 8]);
    end
    exp_flen.push_back(PRE + 1 + supply + (aborted ? 0 : CRC_TAIL));
    exp_abort.push_back(aborted ? 1 : 0);
    exp_ready.push_back(aborted ? supply + 1 : len);
    if (!have_prev) exp_gap.push_back(-1);
    else if (prev_aborted) exp_gap.push_back(((pre_idle > IFG) ? pre_idle : IFG) + 1);
    else exp_gap.push_back(((pre_idle - CRC_TAIL) > IFG) ? (pre_idle - CRC_TAIL) : IFG);
    have_prev = 1;
    prev_aborted = aborted;
    if (aborted) abort_cnt++;
    src_len = len;
    src_supply = supply;
    src_idx = 0;
    idle_left = pre_idle;
    abort_sent = 0;
    src_active = 1;
    driveInputs();
  endtask

  task automatic drainLine();
    int budget;
    budget = 0;
    while ((src_active || in_run || exp_flen.size() != 0 || busy !== 1'b0) && budget < 2000) begin
      stepCycle();
      budget++;
    end
    checkOutput("drain_frames_left", exp_flen.size(), 32'd0);
    checkOutput("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic resetPulse();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_tx_en", 32'(tx_en), 32'd0);
    checkOutput("rst_txd", 32'(txd), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_underflow", 32'(tx_underflow), 32'd0);
    rst_n = 1'b1;
    src_active = 0;
    xfer_pending = 0;
    in_run = 0;
    have_prev = 0;
    zero_run = 0;
    exp_bytes.delete();
    exp_flen.delete();
    exp_abort.delete();
    exp_gap.delete();
    exp_ready.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int act;
    int len, supply, pre;
    repeat (3) @(posedge clk);
    #1;
    resetPulse();

    act = 0;
    for (int i = 0; i < 50; i++) begin
      stepCycle();
      if (tx_en !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) act++;
    end
    checkOutput("idle_activity", act, 32'd0);

    applyStimulus(9, 9, 0, 1);
    applyStimulus(9, 9, 0, 1);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(6, 3, 0, 0);
    applyStimulus(4, 4, 0, 0);
    applyStimulus(3, 3, 20, 0);
    drainLine();

    applyStimulus(10, 10, 0, 0);
    for (int k = 0; k < 100 && src_idx < 3; k++) stepCycle();
    checkOutput("reached_data", 32'(src_idx >= 3), 32'd1);
    resetPulse();
    applyStimulus(5, 5, 0, 0);
    drainLine();

    for (int f = 0; f < 16; f++) begin
      len = $urandom_range(1, 16);
      supply = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : len;
      pre = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      applyStimulus(len, supply, pre, 0);
    end
    drainLine();

    checkOutput("txd_zero_when_idle", idle_txd_viol, 32'd0);
    checkOutput("ready_outside_frame", ready_viol, 32'd0);
    checkOutput("underflow_total", uf_cnt, abort_cnt);
    checkOutput("bytes_left", exp_bytes.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
